// File: rtl/rx_mode_ctrl.sv
// Redundancy mode controller: synchronises and debounces the mode switches and
// applies a new mode only in an idle gap, followed by a pipeline reset pulse.
module rx_mode_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int IDLE_GAP      = 12,
    parameter int RST_CYCLES    = 4
) (
    input  logic        clk125MHz,
    input  logic        reset,
    input  logic [1:0]  mode_req,
    input  logic        en_in,
    input  logic        loss_in,
    output logic [1:0]  mode_sel,
    output logic [2:0]  redundancy,
    output logic        pipe_rst,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] loss_cnt
);

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int GW = $clog2(IDLE_GAP + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {RUN, WAIT_GAP, FLUSH} state_t;

    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
    logic [1:0]    cand_q, cand_d;
    logic [1:0]    acc_q, acc_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [1:0]    mode_sel_q, mode_sel_d;
    logic          en_q, loss_q;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]   loss_cnt_q, loss_cnt_d;
    logic [1:0]    synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], mode_req};
        cand_d = cand_q;
        acc_d  = acc_q;
        stab_d = stab_q;
        if (synced != cand_q) begin
            cand_d = synced;
            stab_d = '0;
        end else if (stab_q == SW'(STABLE_CYCLES - 1)) begin
            acc_d = cand_q;
        end else begin
            stab_d = stab_q + SW'(1);
        end
    end

    // The gap must be IDLE_GAP unbroken idle cycles; any en_in restarts it.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        rst_cnt_d  = rst_cnt_q;
        mode_sel_d = mode_sel_q;
        unique case (state_q)
            RUN: begin
                gap_d = '0;
                if (acc_q != mode_sel_q) state_d = WAIT_GAP;
            end
            WAIT_GAP: begin
                if (acc_q == mode_sel_q) begin
                    state_d = RUN;
                    gap_d   = '0;
                end else if (en_in) begin
                    gap_d = '0;
                end else if (gap_q == GW'(IDLE_GAP - 1)) begin
                    mode_sel_d = acc_q;
                    state_d    = FLUSH;
                    gap_d      = '0;
                    rst_cnt_d  = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            FLUSH: begin
                if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                    state_d   = RUN;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        if (state_q == FLUSH) begin
            frame_cnt_d = '0;
            loss_cnt_d  = '0;
        end else begin
            if (en_in && !en_q && frame_cnt_q != 16'hFFFF)
                frame_cnt_d = frame_cnt_q + 16'd1;
            if (loss_in && !loss_q && loss_cnt_q != 16'hFFFF)
                loss_cnt_d = loss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk125MHz or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            sync_q      <= '0;
            cand_q      <= '0;
            acc_q       <= '0;
            stab_q      <= '0;
            gap_q       <= '0;
            rst_cnt_q   <= '0;
            mode_sel_q  <= '0;
            en_q        <= 1'b0;
            loss_q      <= 1'b0;
            frame_cnt_q <= '0;
            loss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cand_q      <= cand_d;
            acc_q       <= acc_d;
            stab_q      <= stab_d;
            gap_q       <= gap_d;
            rst_cnt_q   <= rst_cnt_d;
            mode_sel_q  <= mode_sel_d;
            en_q        <= en_in;
            loss_q      <= loss_in;
            frame_cnt_q <= frame_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    always_comb begin
        unique case (mode_sel_q)
            2'd0:    redundancy = 3'd1;
            2'd1:    redundancy = 3'd3;
            2'd2:    redundancy = 3'd5;
            default: redundancy = 3'd0;
        endcase
    end

    assign mode_sel  = mode_sel_q;
    assign pipe_rst  = (state_q == FLUSH);
    assign busy      = (state_q != RUN);
    assign frame_cnt = frame_cnt_q;
    assign loss_cnt  = loss_cnt_q;

endmodule

// File: tb/tb_rx_mode_ctrl.sv
// Self-checking bench for rx_mode_ctrl: table of mode switches scored through
// an expectation queue, plus directed glitch, gap, counter and reset sequences.
module tb_rx_mode_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  mode_req;
    logic        en_in;
    logic        loss_in;
    logic [1:0]  mode_sel;
    logic [2:0]  redundancy;
    logic        pipe_rst;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [15:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] req;
        logic [1:0] sel;
        logic [2:0] red;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [2:0] red;
    } exp_t;

    vec_t tbl[5];
    exp_t exp_q[$];

    rx_mode_ctrl #(
        .SYNC_STAGES(2),
        .STABLE_CYCLES(8),
        .IDLE_GAP(12),
        .RST_CYCLES(4)
    ) dut (
        .clk125MHz(clk),
        .reset(reset),
        .mode_req(mode_req),
        .en_in(en_in),
        .loss_in(loss_in),
        .mode_sel(mode_sel),
        .redundancy(redundancy),
        .pipe_rst(pipe_rst),
        .busy(busy),
        .frame_cnt(frame_cnt),
        .loss_cnt(loss_cnt)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        en_in    = 1'b0;
        loss_in  = 1'b0;
        mode_req = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic frame(input logic with_loss);
        en_in   = 1'b1;
        loss_in = with_loss;
        repeat (3) step();
        en_in   = 1'b0;
        loss_in = 1'b0;
        repeat (3) step();
    endtask

    task automatic do_switch(input logic [1:0] req);
        int   n;
        logic [1:0] prev;
        exp_t e;
        frame(1'b0);
        frame(1'b1);
        chk("pre_frames", frame_cnt, 2);
        mode_req = req;
        n = 0;
        while (!busy && n < 100) begin
            step();
            n++;
        end
        chk("busy_rise", busy, 1);
        prev = mode_sel;
        n = 0;
        while (mode_sel == prev && n < 100) begin
            step();
            n++;
        end
        chk("gap_len", n, 12);
        n = 0;
        while (pipe_rst && n < 50) begin
            step();
            n++;
        end
        chk("pipe_rst_len", n, 4);
        chk("busy_after", busy, 0);
        chk("frame_clr", frame_cnt, 0);
        chk("loss_clr", loss_cnt, 0);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("mode_sel", mode_sel, e.sel);
            chk("redundancy", redundancy, e.red);
        end
    endtask

    initial begin
        int   n;
        logic seen;

        tbl[0] = '{req: 2'd2, sel: 2'd2, red: 3'd5};
        tbl[1] = '{req: 2'd1, sel: 2'd1, red: 3'd3};
        tbl[2] = '{req: 2'd3, sel: 2'd3, red: 3'd0};
        tbl[3] = '{req: 2'd0, sel: 2'd0, red: 3'd1};
        tbl[4] = '{req: 2'd2, sel: 2'd2, red: 3'd5};

        do_reset();
        chk("rst_mode_sel", mode_sel, 0);
        chk("rst_redundancy", redundancy, 1);
        chk("rst_pipe_rst", pipe_rst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_loss_cnt", loss_cnt, 0);

        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{sel: tbl[i].sel, red: tbl[i].red});
            do_switch(tbl[i].req);
        end

        // glitch shorter than the stability window
        do_reset();
        mode_req = 2'd1;
        repeat (5) step();
        mode_req = 2'd0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busy || mode_sel != 2'd0) seen = 1'b1;
        end
        chk("glitch_ignored", seen, 0);
        chk("glitch_mode_sel", mode_sel, 0);

        // request during a long frame, plus en_in winning on the last gap cycle
        do_reset();
        en_in    = 1'b1;
        mode_req = 2'd1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (mode_sel != 2'd0) seen = 1'b1;
        end
        chk("midframe_hold", seen, 0);
        chk("midframe_busy", busy, 1);
        en_in = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (mode_sel != 2'd0) seen = 1'b1;
        end
        chk("gap_early", seen, 0);
        en_in = 1'b1;
        step();
        chk("en_priority", mode_sel, 0);
        en_in = 1'b0;
        n = 0;
        while (mode_sel != 2'd1 && n < 50) begin
            step();
            n++;
        end
        chk("midframe_gap", n, 12);
        repeat (8) step();

        // request withdrawn before the gap completes
        do_reset();
        en_in    = 1'b1;
        mode_req = 2'd1;
        n = 0;
        while (!busy && n < 100) begin
            step();
            n++;
        end
        chk("wd_busy", busy, 1);
        mode_req = 2'd0;
        seen = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
            if (pipe_rst) seen = 1'b1;
        end
        chk("wd_busy_fall", busy, 0);
        en_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (pipe_rst || busy) seen = 1'b1;
        end
        chk("wd_no_flush", seen, 0);
        chk("wd_mode_sel", mode_sel, 0);

        // frame and loss counters with saturation
        do_reset();
        frame(1'b1);
        frame(1'b0);
        frame(1'b1);
        chk("frame_cnt3", frame_cnt, 3);
        chk("loss_cnt2", loss_cnt, 2);
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFD;
        force dut.loss_cnt_q  = 16'hFFFD;
        #1;
        release dut.frame_cnt_q;
        release dut.loss_cnt_q;
        step();
        frame(1'b1);
        frame(1'b1);
        chk("frame_at_max", frame_cnt, 16'hFFFF);
        chk("loss_at_max", loss_cnt, 16'hFFFF);
        frame(1'b1);
        frame(1'b1);
        chk("frame_sat", frame_cnt, 16'hFFFF);
        chk("loss_sat", loss_cnt, 16'hFFFF);

        // reset during the second pipe_rst cycle
        do_reset();
        mode_req = 2'd2;
        n = 0;
        while (!pipe_rst && n < 200) begin
            step();
            n++;
        end
        chk("rst_seq_pipe1", pipe_rst, 1);
        step();
        chk("rst_seq_pipe2", pipe_rst, 1);
        mode_req = 2'd0;
        #1;
        reset = 1'b1;
        #1;
        chk("async_pipe_rst", pipe_rst, 0);
        chk("async_mode_sel", mode_sel, 0);
        chk("async_redundancy", redundancy, 1);
        chk("async_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (pipe_rst || busy) seen = 1'b1;
        end
        chk("post_rst_run", seen, 0);
        chk("post_rst_sel", mode_sel, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
